// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, serviced from an internal
// byte-addressed RAM after WAIT_CYCLES wait states, answered over a response handshake.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [2**ADDR_WIDTH];

  logic                  w_accept;
  logic                  w_go;
  logic                  w_wr;
  logic [1:0]            w_size;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [1:0]            w_lane;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_err;
  logic [31:0]           w_old;
  logic [3:0]            w_bmask;
  logic [31:0]           w_wword;
  logic [31:0]           w_rdata;

  assign w_accept = req_valid && r_req_ready;
  // With no wait states the acceptance edge is also the access edge, so the
  // access is computed straight from the request inputs instead of the latches.
  assign w_go = ((r_state == IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                ((r_state == WAIT) && (r_cnt == 4'd1));

  assign w_wr    = (r_state == IDLE) ? req_write : r_write;
  assign w_size  = (r_state == IDLE) ? req_size  : r_size;
  assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_lane  = w_addr[1:0];
  assign w_idx   = w_addr[ADDR_WIDTH+1:2];
  assign w_old   = r_mem[w_idx];

  assign w_err = ((w_addr >> (ADDR_WIDTH + 2)) != '0) ||
                 (w_size == 2'b11) ||
                 ((w_size == 2'b00) && (w_lane != 2'b00)) ||
                 ((w_size == 2'b01) && w_lane[0]);

  always_comb begin
    w_bmask = '0;
    w_wword = '0;
    w_rdata = '0;
    case (w_size)
      2'b00: begin
        w_bmask = 4'hF;
        w_wword = w_wdata;
        w_rdata = w_old;
      end
      2'b01: begin
        w_bmask = 4'b0011 << w_lane;
        w_wword = {2{w_wdata[15:0]}};
        w_rdata = {16'b0, w_old[{w_lane[1], 4'b0000} +: 16]};
      end
      2'b10: begin
        w_bmask = 4'b0001 << w_lane;
        w_wword = {4{w_wdata[7:0]}};
        w_rdata = {24'b0, w_old[{w_lane, 3'b000} +: 8]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset && w_go && w_wr && !w_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_bmask[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_go) begin
        r_state      <= RESP;
        r_resp_valid <= 1'b1;
        r_err        <= w_err;
        r_rdata      <= (w_wr || w_err) ? '0 : w_rdata;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write     <= req_write;
            r_size      <= req_size;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= 4'(WAIT_CYCLES);
            r_req_ready <= 1'b0;
            if (WAIT_CYCLES != 0) r_state <= WAIT;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WAIT: r_cnt <= r_cnt - 4'd1;
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance for functional
// cases and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_mem_responder;

  logic clock, reset;
  int   total = 0;
  int   bad   = 0;

  logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_err;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  logic        t_wr [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [1:0]  t_sz [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
  logic [31:0] t_ad [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h5, 32'hA, 32'hC};
  logic [31:0] t_wd [8] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
                            32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] t_ex [8] = '{32'h0, 32'h0, 32'h0, 32'h0,
                            32'h03020100, 32'h00000005, 32'h00000B0A, 32'h0F0E0D0C};

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_a (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_size(a_req_size), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_b (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Full transaction on the WAIT_CYCLES=2 instance, starting and ending at a negedge in IDLE.
  task automatic xact(input string tag, input logic wr, input logic [1:0] sz,
                      input logic [31:0] ad, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    a_req_write = wr; a_req_size = sz; a_req_addr = ad; a_req_wdata = wd;
    a_req_valid = 1'b1;
    while (a_req_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    chk({tag, "/accept"}, 32'(a_req_ready), 32'd1);
    @(negedge clock);
    a_req_valid = 1'b0;
    n = 1;
    while (a_resp_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    chk({tag, "/latency"}, 32'(n), 32'd3);
    chk({tag, "/rdata"}, a_resp_rdata, exp_d);
    chk({tag, "/err"}, 32'(a_resp_err), 32'(exp_e));
    chk({tag, "/ready_low"}, 32'(a_req_ready), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_size = 2'b00; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = 2'b00; b_req_addr = '0; b_req_wdata = '0;
    a_resp_ready = 1'b1; b_resp_ready = 1'b1;
    @(negedge clock); @(negedge clock);
    chk("rst/req_ready", 32'(a_req_ready), 32'd0);
    chk("rst/resp_valid", 32'(a_resp_valid), 32'd0);
    chk("rst/rdata", a_resp_rdata, 32'd0);
    chk("rst/err", 32'(a_resp_err), 32'd0);
    chk("rst0/req_ready", 32'(b_req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst/req_ready", 32'(a_req_ready), 32'd1);
    chk("post_rst0/req_ready", 32'(b_req_ready), 32'd1);

    xact("st_word", 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("ld_word", 1'b0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("st_byte", 1'b1, 2'b10, 32'h11, 32'h00000055, 32'h0, 1'b0);
    xact("st_half", 1'b1, 2'b01, 32'h12, 32'h00001234, 32'h0, 1'b0);
    xact("ld_merge", 1'b0, 2'b00, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    xact("ld_byte13", 1'b0, 2'b10, 32'h13, 32'h0, 32'h00000012, 1'b0);
    xact("ld_half10", 1'b0, 2'b01, 32'h10, 32'h0, 32'h000055EF, 1'b0);
    xact("st_top", 1'b1, 2'b00, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("ld_top", 1'b0, 2'b00, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0);

    xact("err_misword", 1'b0, 2'b00, 32'h12, 32'h0, 32'h0, 1'b1);
    xact("err_mishalf", 1'b1, 2'b01, 32'h11, 32'h0000FFFF, 32'h0, 1'b1);
    xact("err_range", 1'b0, 2'b00, 32'h400, 32'h0, 32'h0, 1'b1);
    xact("err_size", 1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1);
    xact("err_size_st", 1'b1, 2'b11, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("ld_after_err", 1'b0, 2'b00, 32'h10, 32'h0, 32'h123455EF, 1'b0);

    // Backpressure: response held while spurious stores to 0x10 are offered.
    a_resp_ready = 1'b0;
    a_req_write = 1'b0; a_req_size = 2'b00; a_req_addr = 32'h10; a_req_wdata = '0;
    a_req_valid = 1'b1;
    chk("bp/ready", 32'(a_req_ready), 32'd1);
    @(negedge clock);
    a_req_write = 1'b1;
    n = 1;
    while (a_resp_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    chk("bp/latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp/resp_valid", 32'(a_resp_valid), 32'd1);
      chk("bp/rdata", a_resp_rdata, 32'h123455EF);
      chk("bp/req_ready", 32'(a_req_ready), 32'd0);
      a_req_valid = ~a_req_valid;
      @(negedge clock);
    end
    a_resp_ready = 1'b1;
    a_req_valid = 1'b0;
    @(negedge clock);
    chk("bp/ready_after", 32'(a_req_ready), 32'd1);
    chk("bp/valid_after", 32'(a_resp_valid), 32'd0);
    xact("bp/ld_check", 1'b0, 2'b00, 32'h10, 32'h0, 32'h123455EF, 1'b0);

    // Reset during WAIT aborts the store.
    xact("st_pre20", 1'b1, 2'b00, 32'h20, 32'h11223344, 32'h0, 1'b0);
    a_req_write = 1'b1; a_req_size = 2'b00; a_req_addr = 32'h20; a_req_wdata = 32'hAAAAAAAA;
    a_req_valid = 1'b1;
    @(negedge clock);
    a_req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst/req_ready", 32'(a_req_ready), 32'd0);
    chk("mid_rst/resp_valid", 32'(a_resp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst/ready_after", 32'(a_req_ready), 32'd1);
    xact("mid_rst/ld20", 1'b0, 2'b00, 32'h20, 32'h0, 32'h11223344, 1'b0);

    // Zero wait states, request and response handshakes held high.
    b_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("w0/req_ready", 32'(b_req_ready), 32'd1);
      chk("w0/idle_valid", 32'(b_resp_valid), 32'd0);
      b_req_write = t_wr[i]; b_req_size = t_sz[i]; b_req_addr = t_ad[i]; b_req_wdata = t_wd[i];
      @(negedge clock);
      chk("w0/resp_valid", 32'(b_resp_valid), 32'd1);
      chk("w0/resp_ready_low", 32'(b_req_ready), 32'd0);
      chk("w0/rdata", b_resp_rdata, t_ex[i]);
      chk("w0/err", 32'(b_resp_err), 32'd0);
      @(negedge clock);
    end
    b_req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
